splash_painter: RTL and testbench

Frame painter that sits directly downstream of the splash-screen controller. It watches the one-hot-ish screen requests (title, game-over, black clear) and sweeps the full 160x120 VGA framebuffer once per new request, issuing one pixel write per cycle to the VGA adapter. Title and game-over pixels come from an external synchronous image ROM; black-clear writes a constant colour. The painter handles ROM read latency, abort/restart on request changes, and a completion pulse.

---
 rtl/splash_painter.sv | 203 ++++++++++++++++++++
 tb/tb_splash_painter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/splash_painter.sv
// splash_painter
//
// Sweeps a WIDTH x HEIGHT framebuffer once per new screen request, issuing
// one VGA pixel write per clock. Title and game-over pixels come from an
// external synchronous image ROM; black-clear writes BG_COLOUR.
//
// Handshake: plot is a plain write strobe. Each cycle plot is high, the
// adapter must accept (x, y, colour). There is no back-pressure. done is a
// single-cycle pulse one cycle after the last pixel of a completed sweep.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   showTitle     request: paint title image
//   showGameOver  request: paint game-over image
//   drawBlack     request: clear screen to BG_COLOUR
//   rom_data      ROM pixel colour, valid one cycle after rom_addr
//   rom_addr      pixel index py*WIDTH+px into the selected image
//   rom_sel       0 = title image, 1 = game-over image
//   x, y          VGA write coordinate
//   colour        VGA write colour
//   plot          VGA write enable
//   busy          high while a sweep (or its final flush) is in progress
//   done          one-cycle completion pulse
//   dbg_state     current FSM state (0 IDLE, 1 SWEEP, 2 FLUSH)
module splash_painter #(
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        showTitle,
  input  logic        showGameOver,
  input  logic        drawBlack,
  input  logic [2:0]  rom_data,
  output logic [14:0] rom_addr,
  output logic        rom_sel,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    MODE_NONE     = 2'd0,
    MODE_TITLE    = 2'd1,
    MODE_GAMEOVER = 2'd2,
    MODE_BLACK    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [7:0]  PX_LAST = 8'(WIDTH - 1);
  localparam logic [6:0]  PY_LAST = 7'(HEIGHT - 1);
  localparam logic [14:0] ADDR_W  = 15'(WIDTH);

  // Registered state
  state_t     state, state_n;
  mode_t      mode, mode_n;        // mode of the sweep in progress
  mode_t      painted, painted_n;  // last mode painted or being painted
  logic [7:0] px, px_n;
  logic [6:0] py, py_n;
  logic       done_n;
  logic       valid_n;

  // Output pipeline stage: aligns coordinates with the ROM's one-cycle latency
  logic [7:0] pipe_x;
  logic [6:0] pipe_y;
  logic       pipe_valid;
  logic       pipe_black;

  // Request decode, drawBlack has highest priority
  mode_t req;
  always_comb begin
    req = MODE_NONE;
    if (drawBlack)         req = MODE_BLACK;
    else if (showGameOver) req = MODE_GAMEOVER;
    else if (showTitle)    req = MODE_TITLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next-state and control
  always_comb begin
    state_n   = state;
    mode_n    = mode;
    painted_n = (req == MODE_NONE) ? MODE_NONE : painted;
    px_n      = px;
    py_n      = py;
    valid_n   = 1'b0;
    done_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req != MODE_NONE && req != painted) begin
          state_n   = ST_SWEEP;
          mode_n    = req;
          painted_n = req;
          px_n      = 8'd0;
          py_n      = 7'd0;
        end
      end

      ST_SWEEP: begin
        if (req == MODE_NONE) begin
          // Abort: the pixel currently at the ROM is dropped
          state_n = ST_IDLE;
        end else if (req != mode) begin
          // Restart in the new mode; in-flight pixel dropped
          state_n   = ST_SWEEP;
          mode_n    = req;
          painted_n = req;
          px_n      = 8'd0;
          py_n      = 7'd0;
        end else begin
          valid_n = 1'b1;
          if (px == PX_LAST) begin
            px_n = 8'd0;
            if (py == PY_LAST) begin
              // Hold the counters on the last pixel so rom_addr never
              // runs past the end of the image
              px_n    = px;
              state_n = ST_FLUSH;
            end else begin
              py_n = py + 7'd1;
            end
          end else begin
            px_n = px + 8'd1;
          end
        end
      end

      ST_FLUSH: begin
        if (req == MODE_NONE) begin
          state_n = ST_IDLE;
        end else if (req != mode) begin
          state_n   = ST_SWEEP;
          mode_n    = req;
          painted_n = req;
          px_n      = 8'd0;
          py_n      = 7'd0;
        end else begin
          // Final pixel leaves the pipeline this cycle; done follows
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode       <= MODE_NONE;
      painted    <= MODE_NONE;
      px         <= 8'd0;
      py         <= 7'd0;
      done       <= 1'b0;
      pipe_x     <= 8'd0;
      pipe_y     <= 7'd0;
      pipe_valid <= 1'b0;
      pipe_black <= 1'b0;
    end else begin
      mode       <= mode_n;
      painted    <= painted_n;
      px         <= px_n;
      py         <= py_n;
      done       <= done_n;
      pipe_x     <= px;
      pipe_y     <= py;
      pipe_valid <= valid_n;
      pipe_black <= (mode == MODE_BLACK);
    end
  end

  // Outputs
  assign rom_addr  = 15'(py) * ADDR_W + 15'(px);
  assign rom_sel   = (mode == MODE_GAMEOVER);
  assign x         = pipe_x;
  assign y         = pipe_y;
  assign plot      = pipe_valid;
  // Colour is forced to zero while not plotting so it has a defined idle value
  assign colour    = pipe_valid ? (pipe_black ? BG_COLOUR : rom_data) : 3'b000;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_splash_painter.sv
// Testbench for splash_painter: models the synchronous image ROM, keeps an
// expected-pixel queue filled when requests are driven, and compares every
// plotted pixel against it.
module tb_splash_painter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        show_title = 1'b0;
  logic        show_go = 1'b0;
  logic        draw_black = 1'b0;
  logic [2:0]  rom_data = 3'b000;
  logic [14:0] rom_addr;
  logic        rom_sel;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  splash_painter dut (
    .clk          (clk),
    .rst          (rst),
    .showTitle    (show_title),
    .showGameOver (show_go),
    .drawBlack    (draw_black),
    .rom_data     (rom_data),
    .rom_addr     (rom_addr),
    .rom_sel      (rom_sel),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  initial begin
    #1500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- image ROM model ----------------
  function automatic logic [2:0] rom_fn(input logic sel, input logic [14:0] a);
    if (sel) rom_fn = a[2:0] ^ a[9:7] ^ 3'b101;
    else     rom_fn = a[2:0] + a[10:8];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_sel, rom_addr);

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int plot_count = 0;
  int first_plot = 0;
  int last_plot  = 0;
  int done_count = 0;

  always @(negedge clk) begin
    logic [17:0] got;
    logic [17:0] want;
    if (done === 1'b1) done_count++;
    if (plot === 1'b1) begin
      plot_count++;
      if (plot_count == 1) first_plot = cyc;
      last_plot = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        if (miscompares <= 20)
          $error("FAIL unexpected_plot got x=%0d y=%0d c=%0d want no plot", x, y, colour);
      end else begin
        got  = {x, y, colour};
        want = exp_q.pop_front();
        assert (got === want) else begin
          miscompares++;
          if (miscompares <= 20)
            $error("FAIL pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                   got[17:10], got[9:3], got[2:0], want[17:10], want[9:3], want[2:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // mode: 0 title, 1 game-over, 2 black
  task automatic push_sweep(input int mode, input int count);
    logic [7:0]  xx;
    logic [6:0]  yy;
    logic [2:0]  cc;
    for (int n = 0; n < count; n++) begin
      xx = 8'(n % 160);
      yy = 7'(n / 160);
      cc = (mode == 2) ? 3'b000 : rom_fn(mode == 1, 15'(n));
      exp_q.push_back({xx, yy, cc});
    end
  endtask

  task automatic clear_stats();
    plot_count = 0;
    first_plot = 0;
    last_plot  = 0;
  endtask

  // Drive a request and advance to just after the sampling edge E0
  task automatic drive_req(input logic t, input logic g, input logic b, output int e0);
    show_title = t;
    show_go    = g;
    draw_black = b;
    step();
    e0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int e0);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc - e0), 32'd19201);
    step();
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
    chk({tag, "_x"}, 32'(x), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_colour"}, 32'(colour), 32'd0);
    chk({tag, "_plot"}, 32'(plot), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0;
    int dc;

    #2 rst = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b1;
    repeat (2) step();
    chk("idle_no_req_busy", 32'(busy), 32'd0);

    // Full title sweep
    clear_stats();
    push_sweep(0, 19200);
    drive_req(1'b1, 1'b0, 1'b0, e0);
    chk("title_busy_e0", 32'(busy), 32'd1);
    chk("title_addr_e0", 32'(rom_addr), 32'd0);
    chk("title_plot_e0", 32'(plot), 32'd0);
    chk("title_rom_sel", 32'(rom_sel), 32'd0);
    chk("title_state", 32'(dbg_state), 32'd1);
    step();
    chk("title_addr_1", 32'(rom_addr), 32'd1);
    chk("title_first_xy", 32'({x, y}), 32'd0);
    wait_done("title", e0);
    chk("title_plot_count", 32'(plot_count), 32'd19200);
    chk("title_first_plot", 32'(first_plot - e0), 32'd1);
    chk("title_last_plot", 32'(last_plot - e0), 32'd19200);
    chk("title_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("title_addr_max", 32'(rom_addr), 32'd19199);

    // Full black sweep, switching straight from the completed title
    clear_stats();
    push_sweep(2, 19200);
    drive_req(1'b0, 1'b0, 1'b1, e0);
    chk("black_busy_e0", 32'(busy), 32'd1);
    wait_done("black", e0);
    chk("black_plot_count", 32'(plot_count), 32'd19200);
    chk("black_queue_empty", 32'(exp_q.size()), 32'd0);

    // Title + game-over together selects game-over
    clear_stats();
    push_sweep(1, 300);
    drive_req(1'b1, 1'b1, 1'b0, e0);
    chk("prio_go_rom_sel", 32'(rom_sel), 32'd1);
    repeat (300) step();
    drive_req(1'b0, 1'b0, 1'b0, e0);
    chk("prio_go_drop_plot", 32'(plot), 32'd0);
    chk("prio_go_drop_busy", 32'(busy), 32'd0);
    chk("prio_go_queue", 32'(exp_q.size()), 32'd0);

    // Game-over + black together selects black
    clear_stats();
    push_sweep(2, 300);
    drive_req(1'b0, 1'b1, 1'b1, e0);
    chk("prio_black_busy", 32'(busy), 32'd1);
    repeat (300) step();
    drive_req(1'b0, 1'b0, 1'b0, e0);
    chk("prio_black_queue", 32'(exp_q.size()), 32'd0);
    chk("prio_black_plots", 32'(plot_count), 32'd300);

    // Title, switch to game-over at pixel 5000
    dc = done_count;
    clear_stats();
    push_sweep(0, 5000);
    drive_req(1'b1, 1'b0, 1'b0, e0);
    repeat (5000) step();
    chk("switch_addr_before", 32'(rom_addr), 32'd5000);
    push_sweep(1, 19200);
    drive_req(1'b1, 1'b1, 1'b0, e0);
    chk("switch_plot_low", 32'(plot), 32'd0);
    chk("switch_addr_zero", 32'(rom_addr), 32'd0);
    chk("switch_rom_sel", 32'(rom_sel), 32'd1);
    wait_done("switch", e0);
    chk("switch_done_count", 32'(done_count - dc), 32'd1);
    chk("switch_plots", 32'(plot_count), 32'd24200);
    chk("switch_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same request held: no repaint
    clear_stats();
    dc = done_count;
    repeat (2000) step();
    chk("hold_no_plots", 32'(plot_count), 32'd0);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_no_done", 32'(done_count - dc), 32'd0);

    // Title dropped at pixel 100, then re-asserted
    clear_stats();
    dc = done_count;
    push_sweep(0, 100);
    drive_req(1'b1, 1'b0, 1'b0, e0);
    repeat (100) step();
    drive_req(1'b0, 1'b0, 1'b0, e0);
    chk("drop_plot_low", 32'(plot), 32'd0);
    chk("drop_busy_low", 32'(busy), 32'd0);
    chk("drop_queue", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    chk("drop_no_done", 32'(done_count - dc), 32'd0);
    push_sweep(0, 500);
    drive_req(1'b1, 1'b0, 1'b0, e0);
    chk("reassert_busy", 32'(busy), 32'd1);
    chk("reassert_addr", 32'(rom_addr), 32'd0);
    repeat (500) step();
    drive_req(1'b0, 1'b0, 1'b0, e0);
    chk("reassert_queue", 32'(exp_q.size()), 32'd0);
    chk("reassert_plots", 32'(plot_count), 32'd600);

    // Async reset at pixel 300
    clear_stats();
    push_sweep(1, 300);
    drive_req(1'b0, 1'b1, 1'b0, e0);
    repeat (300) step();
    chk("rst_mid_plot_before", 32'(plot), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_values("rst_mid");
    show_go = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    chk("rst_release_idle", 32'(busy), 32'd0);
    chk("rst_queue", 32'(exp_q.size()), 32'd0);
    clear_stats();
    push_sweep(1, 10);
    drive_req(1'b0, 1'b1, 1'b0, e0);
    chk("rst_restart_busy", 32'(busy), 32'd1);
    chk("rst_restart_sel", 32'(rom_sel), 32'd1);
    repeat (10) step();
    drive_req(1'b0, 1'b0, 1'b0, e0);
    chk("rst_restart_queue", 32'(exp_q.size()), 32'd0);
    chk("total_done_count", 32'(done_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
